// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage constants, RUN/HALT state encoding and the IF/ID payload layout.
package cpu_fetch_pkg;

  localparam logic [15:0] RESET_PC   = 16'h0000;
  localparam logic [15:0] PC_INC     = 16'd2;
  localparam logic [3:0]  HLT_OPCODE = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
    logic        pred_taken;
    logic [15:0] pred_target;
    logic        valid;
  } if_id_t;

  // 16-bit sum drops the carry, so 16'hFFFE wraps to 16'h0000.
  function automatic logic [15:0] pc_plus_inc(input logic [15:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: clr bubbles the slot (valid only), wen loads, otherwise holds.
module if_id_pipe_reg
  import cpu_fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   wen,
  input  logic   clr,
  input  if_id_t data_i,
  output if_id_t data_o
);

  if_id_t data_d;
  if_id_t data_q;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d.valid = 1'b0;
    end else if (wen) begin
      data_d = data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/pc_control.sv
// Fetch PC sequencing with redirect, stall, RUN/HALT FSM and the IF/ID register.
// Optional saturating branch/mispredict counters are enabled by defining BRANCH_STATS_EN.
module pc_control
  import cpu_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_fetch,
  input  logic        predicted_taken,
  input  logic [15:0] predicted_target,
  input  logic        misprediction,
  input  logic        actual_taken,
  input  logic [15:0] actual_target,
  input  logic        is_branch,
  output logic [15:0] PC_curr,
  output logic        predictor_enable,
  output logic [15:0] IF_ID_PC_curr,
  output logic [15:0] IF_ID_PC_next,
  output logic        IF_ID_predicted_taken,
  output logic [15:0] IF_ID_predicted_target,
  output logic        IF_ID_valid,
  output logic        flush,
  output logic        halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
`endif
);

  fetch_state_e state_d, state_q;
  logic [15:0]  pc_d, pc_q;
  if_id_t       if_id_in, if_id_out;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (misprediction) begin
      // Redirect wins over stall and halt; a HLT seen while halted was on the wrong path.
      pc_d = actual_taken ? actual_target : if_id_out.pc_next;
      if (state_q == ST_HALT) state_d = ST_RUN;
    end else if (!stall) begin
      if (state_q == ST_RUN) begin
        if (halt_fetch) begin
          state_d = ST_HALT;
        end else if (predicted_taken) begin
          pc_d = predicted_target;
        end else begin
          pc_d = pc_plus_inc(pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign if_id_in = '{pc_curr:     pc_q,
                      pc_next:     pc_plus_inc(pc_q),
                      pred_taken:  predicted_taken,
                      pred_target: predicted_target,
                      valid:       (state_q == ST_RUN)};

  if_id_pipe_reg u_if_id (
    .clk    (clk),
    .rst    (rst),
    .wen    (~stall),
    .clr    (misprediction),
    .data_i (if_id_in),
    .data_o (if_id_out)
  );

  assign PC_curr                = pc_q;
  assign predictor_enable       = ~stall;
  assign IF_ID_PC_curr          = if_id_out.pc_curr;
  assign IF_ID_PC_next          = if_id_out.pc_next;
  assign IF_ID_predicted_taken  = if_id_out.pred_taken;
  assign IF_ID_predicted_target = if_id_out.pred_target;
  assign IF_ID_valid            = if_id_out.valid;
  assign flush                  = misprediction;
  assign halted                 = (state_q == ST_HALT);

`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count_d, branch_count_q;
  logic [15:0] mispredict_count_d, mispredict_count_q;

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (is_branch && !stall && (branch_count_q != 16'hFFFF))
      branch_count_d = branch_count_q + 16'd1;
    if (misprediction && (mispredict_count_q != 16'hFFFF))
      mispredict_count_d = mispredict_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;
`else
  logic unused_is_branch;
  assign unused_is_branch = is_branch;
`endif

endmodule
